// File: rtl/alu_issue_if.sv
// Issue-stage bundle: decoded-register-read side in, ALU operand/select side out.
// The master modport is the issue stage itself; slave is its environment.
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  Data_sel;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;

    modport master (
        input  in_valid, in_instr, in_pc, in_rs1, in_rs2, flush, out_ready,
        output in_ready, out_valid, A, B, Data_sel, rd, rd_we, illegal
    );

    modport slave (
        output in_valid, in_instr, in_pc, in_rs1, in_rs2, flush, out_ready,
        input  in_ready, out_valid, A, B, Data_sel, rd, rd_we, illegal
    );
endinterface

// File: rtl/alu_issue.sv
// RV32I issue stage: decodes operands and ALU select, registered output with a
// one-entry skid so ALU stalls never drop or reorder instructions.
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.master bus
);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } entry_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] SEL_ADD  = 4'b0000;
    localparam logic [3:0] SEL_SUB  = 4'b0001;
    localparam logic [3:0] SEL_PASS = 4'b1111;

    // funct3 -> ALU op; alt picks sub for 000 and sra for 101
    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
        logic [3:0] s;
        case (f3)
            3'b000:  s = alt ? 4'b0001 : 4'b0000;
            3'b001:  s = 4'b0101;
            3'b010:  s = 4'b0111;
            3'b011:  s = 4'b1000;
            3'b100:  s = 4'b0100;
            3'b101:  s = alt ? 4'b1001 : 4'b0110;
            3'b110:  s = 4'b0011;
            default: s = 4'b0010;
        endcase
        return s;
    endfunction

    function automatic entry_t decode(input logic [31:0] instr, input logic [31:0] pc,
                                      input logic [31:0] rs1, input logic [31:0] rs2);
        entry_t             e;
        logic [6:0]         opc;
        logic [2:0]         f3;
        logic [6:0]         f7;
        logic signed [31:0] imm_i;
        logic signed [31:0] imm_s;
        logic [31:0]        imm_u;
        logic               is_shift;

        opc      = instr[6:0];
        f3       = instr[14:12];
        f7       = instr[31:25];
        imm_i    = {{20{instr[31]}}, instr[31:20]};
        imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_u    = {instr[31:12], 12'b0};
        is_shift = (f3 == 3'b001) || (f3 == 3'b101);

        e    = '0;
        e.rd = instr[11:7];
        case (opc)
            OPC_OP: begin
                e.a     = rs1;
                e.b     = rs2;
                e.rd_we = 1'b1;
                if (f7 == 7'b0000000 ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
                    e.sel = alu_sel(f3, f7[5]);
                else
                    e.illegal = 1'b1;
            end
            OPC_OPIMM: begin
                e.a     = rs1;
                e.b     = is_shift ? {27'b0, instr[24:20]} : imm_i;
                e.sel   = alu_sel(f3, (f3 == 3'b101) && f7[5]);
                e.rd_we = 1'b1;
            end
            OPC_LUI: begin
                e.a     = imm_u;
                e.sel   = SEL_PASS;
                e.rd_we = 1'b1;
            end
            OPC_AUIPC: begin
                e.a     = pc;
                e.b     = imm_u;
                e.sel   = SEL_ADD;
                e.rd_we = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                e.a     = pc + 32'd4;
                e.sel   = SEL_PASS;
                e.rd_we = 1'b1;
            end
            OPC_LOAD: begin
                e.a     = rs1;
                e.b     = imm_i;
                e.sel   = SEL_ADD;
                e.rd_we = 1'b1;
            end
            OPC_STORE: begin
                e.a   = rs1;
                e.b   = imm_s;
                e.sel = SEL_ADD;
            end
            OPC_BRANCH: begin
                e.a   = rs1;
                e.b   = rs2;
                e.sel = SEL_SUB;
            end
            default: e.illegal = 1'b1;
        endcase

        if (e.illegal) begin
            e.a     = '0;
            e.b     = '0;
            e.sel   = SEL_ADD;
            e.rd_we = 1'b0;
        end
        if (e.rd == 5'd0)
            e.rd_we = 1'b0;
        return e;
    endfunction

    entry_t dec;
    entry_t out_p0;
    entry_t skid_p1;
    logic   vld_p0;
    logic   vld_p1;
    logic   rdy_q;
    logic   take_in;
    logic   take_out;

    assign dec      = decode(bus.in_instr, bus.in_pc, bus.in_rs1, bus.in_rs2);
    assign take_in  = bus.in_valid & rdy_q;
    assign take_out = vld_p0 & bus.out_ready;

    // ---- output register (p0) and skid entry (p1) ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            rdy_q   <= 1'b0;
            out_p0  <= '0;
            skid_p1 <= '0;
        end else if (bus.flush) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            rdy_q  <= 1'b1;
        end else if (vld_p1) begin
            // in_ready is low here, so only the drain path can move
            if (take_out) begin
                out_p0 <= skid_p1;
                vld_p1 <= 1'b0;
                rdy_q  <= 1'b1;
            end
        end else if (!vld_p0 || take_out) begin
            if (take_in)
                out_p0 <= dec;
            vld_p0 <= take_in;
            rdy_q  <= 1'b1;
        end else if (take_in) begin
            skid_p1 <= dec;
            vld_p1  <= 1'b1;
            rdy_q   <= 1'b0;
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = vld_p0;
    assign bus.A         = out_p0.a;
    assign bus.B         = out_p0.b;
    assign bus.Data_sel  = out_p0.sel;
    assign bus.rd        = out_p0.rd;
    assign bus.rd_we     = out_p0.rd_we;
    assign bus.illegal   = out_p0.illegal;

endmodule
